// File: rtl/gpio_cond_pkg.sv
// Shared constants, counter-width helper and edge bundle
// for the GPIO pin conditioner.
package gpio_cond_pkg;

  localparam int GPIO_WIDTH_DEF      = 24;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Bypass mode still needs a legal 1-bit vector
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_pin_conditioner_if.sv
// Register-block <-> pad conditioner bundle.
// GPIO_COND_LOOPBACK_EN adds the LOOPBACK self-test select.
interface gpio_pin_conditioner_if
  import gpio_cond_pkg::*;
#(
  parameter int W = GPIO_WIDTH_DEF
);

  logic [W-1:0] DIR;
  logic [W-1:0] WDATA;
  logic [W-1:0] PAD_IN;
  logic [W-1:0] PAD_OUT;
  logic [W-1:0] PAD_OE;
  logic [W-1:0] RDATA;
  logic [W-1:0] IRQ_RISE_MASK;
  logic [W-1:0] IRQ_FALL_MASK;
  logic [W-1:0] IRQ_CLR;
  logic [W-1:0] IRQ_STATUS;
  logic         IRQ;

`ifdef GPIO_COND_LOOPBACK_EN
  logic LOOPBACK;

  modport master (
    output DIR, WDATA, PAD_IN,
    output IRQ_RISE_MASK, IRQ_FALL_MASK,
    output IRQ_CLR, LOOPBACK,
    input  PAD_OUT, PAD_OE, RDATA,
    input  IRQ_STATUS, IRQ
  );

  modport slave (
    input  DIR, WDATA, PAD_IN,
    input  IRQ_RISE_MASK, IRQ_FALL_MASK,
    input  IRQ_CLR, LOOPBACK,
    output PAD_OUT, PAD_OE, RDATA,
    output IRQ_STATUS, IRQ
  );
`else
  modport master (
    output DIR, WDATA, PAD_IN,
    output IRQ_RISE_MASK, IRQ_FALL_MASK,
    output IRQ_CLR,
    input  PAD_OUT, PAD_OE, RDATA,
    input  IRQ_STATUS, IRQ
  );

  modport slave (
    input  DIR, WDATA, PAD_IN,
    input  IRQ_RISE_MASK, IRQ_FALL_MASK,
    input  IRQ_CLR,
    output PAD_OUT, PAD_OE, RDATA,
    output IRQ_STATUS, IRQ
  );
`endif

endinterface

// File: rtl/gpio_pin_conditioner_debounce_bit.sv
// One pin: synchroniser chain, debounce counter,
// accepted-value register and registered edge pulses.
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  din,
  output logic  stable,
  output edge_t edges
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync;
  logic                   update;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign sync = chain[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign update = sync != stable;
    end else begin : g_count
      localparam logic [CW-1:0] LAST =
        CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;

      // Clears on agreement, on acceptance, or on bounce
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt <= '0;
        else if (sync == stable || cnt == LAST)
          cnt <= '0;
        else
          cnt <= cnt + 1'b1;
      end

      assign update = (sync != stable) && (cnt == LAST);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable     <= 1'b0;
      edges.rise <= 1'b0;
      edges.fall <= 1'b0;
    end else begin
      if (update) stable <= sync;
      edges.rise <= update & sync;
      edges.fall <= update & ~sync;
    end
  end

endmodule

// File: rtl/gpio_pin_conditioner.sv
// Pad-side GPIO conditioner: output registers, debounced
// inputs, sticky edge IRQ. GPIO_COND_LOOPBACK_EN adds self-test.
module gpio_pin_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int GPIO_WIDTH      = GPIO_WIDTH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic HCLK,
  input logic HRESET,
  gpio_pin_conditioner_if.slave bus
);

  logic  [GPIO_WIDTH-1:0] pad_src;
  logic  [GPIO_WIDTH-1:0] stable;
  logic  [GPIO_WIDTH-1:0] rise;
  logic  [GPIO_WIDTH-1:0] fall;
  edge_t [GPIO_WIDTH-1:0] edges;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bus.PAD_OUT <= '0;
      bus.PAD_OE  <= '0;
    end else begin
      bus.PAD_OUT <= bus.WDATA;
      bus.PAD_OE  <= bus.DIR;
    end
  end

`ifdef GPIO_COND_LOOPBACK_EN
  assign pad_src = bus.LOOPBACK
                 ? (bus.PAD_OUT & bus.PAD_OE)
                 : bus.PAD_IN;
`else
  assign pad_src = bus.PAD_IN;
`endif

  genvar i;
  generate
    for (i = 0; i < GPIO_WIDTH; i++) begin : g_pin
      gpio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk   (HCLK),
        .rst   (HRESET),
        .din   (pad_src[i]),
        .stable(stable[i]),
        .edges (edges[i])
      );

      assign rise[i] = edges[i].rise;
      assign fall[i] = edges[i].fall;
    end
  endgenerate

  assign bus.RDATA = stable;

  // Set dominates a coincident clear so no event is lost
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      bus.IRQ_STATUS <= '0;
    else
      bus.IRQ_STATUS <= (bus.IRQ_STATUS & ~bus.IRQ_CLR)
                      | (rise & bus.IRQ_RISE_MASK)
                      | (fall & bus.IRQ_FALL_MASK);
  end

  assign bus.IRQ = |bus.IRQ_STATUS;

endmodule

// File: tb/tb_gpio_pin_conditioner.sv
// Scoreboard bench: pad-sample history model plus directed
// latency, bounce, mask, clear and reset scenarios.
module tb_gpio_pin_conditioner;
  import gpio_cond_pkg::*;

  localparam int W   = 24;
  localparam int S   = 2;
  localparam int D   = 16;
  localparam int LEN = S + D + 1;

  typedef logic [W-1:0] word_t;
  typedef struct packed {
    word_t po;
    word_t oe;
    word_t rd;
    word_t st;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;

  gpio_pin_conditioner_if #(.W(W)) bus ();

  gpio_pin_conditioner #(
    .GPIO_WIDTH     (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  word_t pad_v, dir_v, wd_v, rm_v, fm_v, clr_v;
  logic  rst_v, lb_v;

  // Model state: accepted values and raw pad history
  word_t m_out, m_oe, m_stable, m_status;
  word_t m_rise, m_fall;
  word_t hist[LEN];

  task automatic chk(input string name,
                     input word_t act,
                     input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h",
               name, act, req);
    end
  endtask

  // A pin flips once the last D synchronised samples all
  // disagree with it; sync lags the pad by S edges.
  task automatic model_step();
    word_t src;
    logic  all_diff;
    if (rst_v) begin
      m_out = '0; m_oe = '0; m_stable = '0;
      m_status = '0; m_rise = '0; m_fall = '0;
      for (int j = 0; j < LEN; j++) hist[j] = '0;
    end else begin
      src = pad_v;
`ifdef GPIO_COND_LOOPBACK_EN
      if (lb_v) src = m_out & m_oe;
`endif
      for (int j = LEN - 1; j > 0; j--)
        hist[j] = hist[j-1];
      hist[0] = src;
      m_status = (m_status & ~clr_v)
               | (m_rise & rm_v) | (m_fall & fm_v);
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < ((D == 0) ? 1 : D); j++)
          if (hist[S+j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_stable[b]) m_fall[b] = 1'b1;
          else             m_rise[b] = 1'b1;
          m_stable[b] = ~m_stable[b];
        end
      end
      m_out = wd_v;
      m_oe  = dir_v;
    end
    exp_q.push_back('{m_out, m_oe, m_stable, m_status});
  endtask

  task automatic tick();
    HRESET            = rst_v;
    bus.DIR           = dir_v;
    bus.WDATA         = wd_v;
    bus.PAD_IN        = pad_v;
    bus.IRQ_RISE_MASK = rm_v;
    bus.IRQ_FALL_MASK = fm_v;
    bus.IRQ_CLR       = clr_v;
`ifdef GPIO_COND_LOOPBACK_EN
    bus.LOOPBACK      = lb_v;
`endif
    model_step();
    @(negedge HCLK);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  always @(posedge HCLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_pad_out", bus.PAD_OUT, e.po);
      chk("sb_pad_oe", bus.PAD_OE, e.oe);
      chk("sb_rdata", bus.RDATA, e.rd);
      chk("sb_status", bus.IRQ_STATUS, e.st);
      chk("sb_irq", word_t'(bus.IRQ), word_t'(|e.st));
    end
  end

  initial begin
    pad_v = '0; dir_v = '0; wd_v = '0;
    rm_v = '0; fm_v = '0; clr_v = '0;
    rst_v = 1'b1; lb_v = 1'b0;
    ticks(3);
    chk("rst_rdata", bus.RDATA, '0);
    chk("rst_oe", bus.PAD_OE, '0);
    chk("rst_status", bus.IRQ_STATUS, '0);

    rst_v = 1'b0;
    dir_v = 24'h0000FF;
    wd_v  = 24'h00005A;
    tick();
    chk("out_oe", bus.PAD_OE, 24'h0000FF);
    chk("out_data", bus.PAD_OUT, 24'h00005A);

    rm_v[3] = 1'b1;
    pad_v[3] = 1'b1;
    ticks(17);
    chk("b3_before", word_t'(bus.RDATA[3]), 0);
    tick();
    chk("b3_rdata", word_t'(bus.RDATA[3]), 1);
    chk("b3_st_early", word_t'(bus.IRQ_STATUS[3]), 0);
    tick();
    chk("b3_status", word_t'(bus.IRQ_STATUS[3]), 1);
    chk("b3_irq", word_t'(bus.IRQ), 1);
    rm_v[3] = 1'b0;
    tick();
    chk("b3_mask_keep", word_t'(bus.IRQ_STATUS[3]), 1);

    rm_v[5] = 1'b1;
    pad_v[5] = 1'b1;
    ticks(10);
    pad_v[5] = 1'b0;
    ticks(2);
    chk("b5_bounce", word_t'(bus.RDATA[5]), 0);
    pad_v[5] = 1'b1;
    ticks(17);
    chk("b5_before", word_t'(bus.RDATA[5]), 0);
    tick();
    chk("b5_rdata", word_t'(bus.RDATA[5]), 1);
    tick();
    chk("b5_status", word_t'(bus.IRQ_STATUS[5]), 1);

    pad_v[7] = 1'b1;
    ticks(20);
    pad_v[7] = 1'b0;
    ticks(20);
    chk("b7_rdata", word_t'(bus.RDATA[7]), 0);
    chk("b7_masked", word_t'(bus.IRQ_STATUS[7]), 0);
    fm_v[7] = 1'b1;
    pad_v[7] = 1'b1;
    ticks(20);
    chk("b7_rise_off", word_t'(bus.IRQ_STATUS[7]), 0);
    pad_v[7] = 1'b0;
    ticks(19);
    chk("b7_fall", word_t'(bus.IRQ_STATUS[7]), 1);
    pad_v[7] = 1'b1;
    ticks(20);
    pad_v[7] = 1'b0;
    ticks(18);
    clr_v[7] = 1'b1;
    tick();
    clr_v[7] = 1'b0;
    chk("b7_set_wins", word_t'(bus.IRQ_STATUS[7]), 1);
    clr_v[7] = 1'b1;
    tick();
    clr_v[7] = 1'b0;
    chk("b7_cleared", word_t'(bus.IRQ_STATUS[7]), 0);

    pad_v[2] = 1'b1;
    ticks(10);
    rst_v = 1'b1;
    ticks(2);
    chk("b2_rst", bus.RDATA, '0);
    rst_v = 1'b0;
    ticks(17);
    chk("b2_before", word_t'(bus.RDATA[2]), 0);
    tick();
    chk("b2_rdata", word_t'(bus.RDATA[2]), 1);

`ifdef GPIO_COND_LOOPBACK_EN
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    pad_v = '0; lb_v = 1'b1;
    dir_v = 24'h1; wd_v = 24'h1;
    ticks(18);
    chk("lb_before", word_t'(bus.RDATA[0]), 0);
    tick();
    chk("lb_rdata", word_t'(bus.RDATA[0]), 1);
    lb_v = 1'b0;
`endif

    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(31) == 0) pad_v[b] = ~pad_v[b];
      if ($urandom_range(63) == 0) begin
        rm_v  = word_t'($urandom);
        fm_v  = word_t'($urandom);
        dir_v = word_t'($urandom);
      end
      wd_v  = word_t'($urandom);
      clr_v = ($urandom_range(7) == 0)
            ? word_t'($urandom) : '0;
      rst_v = ($urandom_range(999) == 0);
`ifdef GPIO_COND_LOOPBACK_EN
      if ($urandom_range(127) == 0) lb_v = ~lb_v;
`endif
      tick();
    end

    rst_v = 1'b0;
    clr_v = '0;
    tick();
    for (int k = 0; k < 5 && exp_q.size() > 0; k++)
      @(negedge HCLK);
    chk("sb_drain", word_t'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
